// File: rtl/alu_seq_if.sv
// Bus between the multi-cycle controller and alu_sequencer.
// master: controller side (drives start/alu_op/func/a/b, reads results).
// slave:  ALU side (reads the request, drives result/zero/busy/done/hi/lo).
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [1:0]       alu_op;
  logic [5:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_op, func, a, b,
    input  result, zero, busy, done, hi, lo
  );

  modport slave (
    input  start, alu_op, func, a, b,
    output result, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequential ALU: decodes alu_op/func, runs single-cycle ops in one edge and
// iterative unsigned multu/divu over WIDTH edges into HI/LO.
// Ports: clk, rst (sync, active-high), bus (alu_seq_if.slave):
//   start/alu_op/func/a/b in; result/zero/busy/done/hi/lo out (all registered).
module alu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_DIV, OP_MFHI, OP_MFLO
  } op_t;

  state_t           state_q, state_next;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;
  logic             zero_q, busy_q, done_q;
  // Iteration registers: MUL -> {partial hi, multiplier}, opnd = multiplicand;
  // DIV -> {remainder, quotient/dividend}, opnd = divisor.
  logic [WIDTH-1:0] work_hi_q, work_lo_q, opnd_q;

  op_t              op_c;
  logic [WIDTH-1:0] res_c;
  logic             last_iter_c;
  logic             load_single_c, launch_c, step_c, finish_c;
  logic [WIDTH:0]   sum_c, trial_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;

  // Operation decode
  always_comb begin
    op_c = OP_AND;
    case (bus.alu_op)
      2'b00: op_c = OP_ADD;
      2'b01: op_c = OP_SUB;
      2'b11: op_c = OP_SLT;
      default: begin
        case (bus.func)
          6'b100000: op_c = OP_ADD;
          6'b100011: op_c = OP_SUB;
          6'b100100: op_c = OP_AND;
          6'b100101: op_c = OP_OR;
          6'b101010: op_c = OP_SLT;
          6'b011001: op_c = OP_MUL;
          6'b011011: op_c = OP_DIV;
          6'b010000: op_c = OP_MFHI;
          6'b010010: op_c = OP_MFLO;
          default:   op_c = OP_AND;
        endcase
      end
    endcase
  end

  // Single-cycle result
  always_comb begin
    res_c = bus.a & bus.b;
    case (op_c)
      OP_ADD:  res_c = bus.a + bus.b;
      OP_SUB:  res_c = bus.a - bus.b;
      OP_OR:   res_c = bus.a | bus.b;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_MFHI: res_c = hi_q;
      OP_MFLO: res_c = lo_q;
      default: res_c = bus.a & bus.b;
    endcase
  end

  // One shift-add / restoring shift-subtract iteration
  always_comb begin
    sum_c   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    trial_c = {work_hi_q, work_lo_q[WIDTH-1]} - {1'b0, opnd_q};
    if (state_q == S_MUL) begin
      step_hi_c = sum_c[WIDTH:1];
      step_lo_c = {sum_c[0], work_lo_q[WIDTH-1:1]};
    end else if (!trial_c[WIDTH]) begin
      step_hi_c = trial_c[WIDTH-1:0];
      step_lo_c = {work_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_hi_c = {work_hi_q[WIDTH-2:0], work_lo_q[WIDTH-1]};
      step_lo_c = {work_lo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && op_c == OP_MUL)      state_next = S_MUL;
        else if (bus.start && op_c == OP_DIV) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (last_iter_c) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    load_single_c = 1'b0;
    launch_c      = 1'b0;
    step_c        = 1'b0;
    finish_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_c == OP_MUL || op_c == OP_DIV) launch_c      = 1'b1;
          else                                  load_single_c = 1'b1;
        end
      end
      S_MUL, S_DIV: begin
        step_c   = 1'b1;
        finish_c = last_iter_c;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (load_single_c) begin
        result_q <= res_c;
        zero_q   <= (res_c == '0);
        done_q   <= 1'b1;
      end
      if (launch_c) begin
        cnt_q     <= '0;
        busy_q    <= 1'b1;
        work_hi_q <= '0;
        work_lo_q <= (op_c == OP_MUL) ? bus.b : bus.a;
        opnd_q    <= (op_c == OP_MUL) ? bus.a : bus.b;
      end
      if (step_c) begin
        work_hi_q <= step_hi_c;
        work_lo_q <= step_lo_c;
        cnt_q     <= cnt_q + CNT_W'(1);
      end
      if (finish_c) begin
        hi_q     <= step_hi_c;
        lo_q     <= step_lo_c;
        result_q <= step_lo_c;
        zero_q   <= (step_lo_c == '0);
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        cnt_q    <= '0;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

endmodule
